// File: rtl/mem_access_unit.sv
// Memory access stage for the multicycle controller.
// Turns MemRead/MemWrite/BEOp plus an address into one req/ack bus transaction,
// rejects misaligned accesses without touching the bus, aborts on a missing ack,
// and keeps the extended load result in the MDR.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [2:0]  be_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] mdr_o,
  output logic        stall_o,
  output logic        ready_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last REQ cycle index before the abort; the counter starts at 0 on REQ entry.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic TMO_EN = (TIMEOUT != 0);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  // Access size from BEOp; the store codes 001/010 mean word when reading.
  function automatic logic [1:0] op_size(input logic [2:0] op, input logic we);
    case (op)
      3'b000, 3'b011: op_size = SZ_W;
      3'b001:         op_size = we ? SZ_H : SZ_W;
      3'b010:         op_size = we ? SZ_B : SZ_W;
      3'b100, 3'b101: op_size = SZ_H;
      default:        op_size = SZ_B;
    endcase
  endfunction

  state_t         state_reg, state_next;
  logic [31:0]    addr_reg, wdata_reg, mdr_reg;
  logic [2:0]     be_op_reg;
  logic           we_reg, misalign_reg, err_reg;
  logic [CW-1:0]  cnt_reg;

  logic           req_in, in_misalign, ack_in_req, timeout_hit, ld_signed;
  logic [1:0]     in_size, size_cur;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data, lane_wdata;
  logic [3:0]     lane_be;

  assign req_in      = rd_i | wr_i;
  assign in_size     = op_size(be_op_i, wr_i);
  assign in_misalign = ((in_size == SZ_W) && (addr_i[1:0] != 2'b00)) ||
                       ((in_size == SZ_H) && addr_i[0]);
  assign size_cur    = op_size(be_op_reg, we_reg);
  assign ack_in_req  = (state_reg == S_REQ) && bus_ack_i;
  assign timeout_hit = TMO_EN && (cnt_reg == CNT_LAST);

  // Lane extraction and sign/zero extension of the returning read data.
  assign ld_byte   = bus_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
  assign ld_half   = bus_rdata_i[{addr_reg[1], 4'b0000} +: 16];
  assign ld_signed = (be_op_reg == 3'b101) || (be_op_reg == 3'b111);

  // Select the load result according to the latched access size.
  always_comb begin
    ld_data = bus_rdata_i;
    case (size_cur)
      SZ_H:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      SZ_B:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      default: ld_data = bus_rdata_i;
    endcase
  end

  // Per-lane byte enable and replicated store data; reads enable all lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[8*gi +: 8] =
      (size_cur == SZ_B) ? wdata_reg[7:0] :
      (size_cur == SZ_H) ? wdata_reg[8*(gi%2) +: 8] :
                           wdata_reg[8*gi +: 8];
    assign lane_be[gi] = !we_reg || (size_cur == SZ_W) ||
                         ((size_cur == SZ_H) && (addr_reg[1] == 1'(gi / 2))) ||
                         ((size_cur == SZ_B) && (addr_reg[1:0] == 2'(gi)));
  end

  // State register; async reset drops bus_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: misaligned accesses skip the bus, ack beats timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (req_in) state_next = in_misalign ? S_DONE : S_REQ;
      S_REQ:   if (bus_ack_i || timeout_hit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Access latches, timeout counter, status flags and MDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_op_reg    <= '0;
      we_reg       <= 1'b0;
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      mdr_reg      <= '0;
    end else begin
      if (state_reg == S_IDLE && req_in) begin
        addr_reg     <= addr_i;
        wdata_reg    <= wdata_i;
        be_op_reg    <= be_op_i;
        we_reg       <= wr_i;
        misalign_reg <= in_misalign;
        err_reg      <= 1'b0;
        cnt_reg      <= '0;
      end else if (state_reg == S_REQ) begin
        if (ack_in_req) begin
          if (!we_reg) mdr_reg <= ld_data;
        end else if (timeout_hit) begin
          err_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // Outputs: bus signals only driven while a request is outstanding.
  always_comb begin
    bus_req_o   = (state_reg == S_REQ);
    bus_we_o    = bus_req_o & we_reg;
    bus_addr_o  = bus_req_o ? {addr_reg[31:2], 2'b00} : 32'd0;
    bus_be_o    = bus_req_o ? lane_be : 4'd0;
    bus_wdata_o = bus_req_o ? lane_wdata : 32'd0;
    ready_o     = (state_reg == S_DONE);
    misalign_o  = ready_o & misalign_reg;
    bus_err_o   = ready_o & err_reg;
    stall_o     = req_in & (state_reg != S_DONE);
    mdr_o       = mdr_reg;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, a few
// hand-written multi-cycle sequences, then random accesses against a model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_i, wr_i;
  logic [2:0]  be_op_i;
  logic [31:0] addr_i, wdata_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] mdr_o;
  logic        stall_o, ready_o, misalign_o, bus_err_o;

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;
  logic [31:0] model_mdr = 32'd0;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_i(rd_i), .wr_i(wr_i), .be_op_i(be_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .mdr_o(mdr_o),
    .stall_o(stall_o), .ready_o(ready_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;   // REQ cycle index carrying the ack; -1 = never
    logic [31:0] rdata;
    logic [31:0] exp_mdr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_err;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: derive expected bus/MDR results from the access rules directly.
  function automatic txn_t model(input txn_t t, input logic [31:0] prev);
    int size, ofs;
    logic [31:0] b;
    if (t.wr) size = (t.op == 3'd0) ? 4 : (t.op == 3'd1) ? 2 : 1;
    else      size = (t.op <= 3'd3) ? 4 : (t.op <= 3'd5) ? 2 : 1;
    ofs = int'(t.addr % 4);
    t.exp_mis = (ofs % size) != 0;
    t.exp_err = !t.exp_mis && (t.ack_dly < 0 || t.ack_dly >= TMO);
    if (!t.wr || size == 4) t.exp_be = 4'hF;
    else if (size == 2)     t.exp_be = 4'(3 << ofs);
    else                    t.exp_be = 4'(1 << ofs);
    if (size == 4)      t.exp_wdata = t.wdata;
    else if (size == 2) t.exp_wdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
    else                t.exp_wdata = (t.wdata & 32'hFF) * 32'h0101_0101;
    t.exp_mdr = prev;
    if (!t.wr && !t.exp_mis && !t.exp_err) begin
      b = t.rdata >> (8 * ofs);
      if (size == 4) t.exp_mdr = t.rdata;
      else if (size == 2) begin
        b = b & 32'hFFFF;
        t.exp_mdr = (t.op == 3'd5 && b >= 32'h8000) ? b + 32'hFFFF_0000 : b;
      end else begin
        b = b & 32'hFF;
        t.exp_mdr = (t.op == 3'd7 && b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      end
    end
    return t;
  endfunction

  // Runs one access starting in an IDLE cycle (called at posedge+1);
  // returns at posedge+1 of the following IDLE cycle.
  task automatic run_txn(input txn_t t, input bit hold);
    int k;
    bit done;
    int stalls;
    rd_i = t.rd; wr_i = t.wr; be_op_i = t.op; addr_i = t.addr; wdata_i = t.wdata;
    bus_ack_i = 1'($urandom % 2); bus_rdata_i = $urandom;
    #1;
    chk("idle_stall", 32'(stall_o), 32'd1);
    chk("idle_req", 32'(bus_req_o), 32'd0);
    chk("idle_ready", 32'(ready_o), 32'd0);
    stalls = 1;
    @(posedge clk); #1;
    if (!t.exp_mis) begin
      k = 0; done = 1'b0;
      while (!done) begin
        addr_i = $urandom; wdata_i = $urandom; be_op_i = 3'($urandom);
        bus_ack_i   = (k == t.ack_dly);
        bus_rdata_i = (k == t.ack_dly) ? t.rdata : $urandom;
        #1;
        chk("req_req", 32'(bus_req_o), 32'd1);
        chk("req_we", 32'(bus_we_o), 32'(t.wr));
        chk("req_addr", bus_addr_o, t.addr & 32'hFFFF_FFFC);
        chk("req_be", 32'(bus_be_o), 32'(t.exp_be));
        if (t.wr) chk("req_wdata", bus_wdata_o, t.exp_wdata);
        chk("req_stall", 32'(stall_o), 32'd1);
        chk("req_ready", 32'(ready_o), 32'd0);
        stalls++;
        if (k == t.ack_dly || k == TMO - 1) done = 1'b1;
        k++;
        @(posedge clk); #1;
      end
    end
    bus_ack_i = 1'($urandom % 2); bus_rdata_i = $urandom;
    #1;
    chk("done_ready", 32'(ready_o), 32'd1);
    chk("done_misalign", 32'(misalign_o), 32'(t.exp_mis));
    chk("done_err", 32'(bus_err_o), 32'(t.exp_err));
    chk("done_req", 32'(bus_req_o), 32'd0);
    chk("done_stall", 32'(stall_o), 32'd0);
    chk("done_mdr", mdr_o, t.exp_mdr);
    model_mdr = t.exp_mdr;
    if (!hold) begin rd_i = 1'b0; wr_i = 1'b0; end
    bus_ack_i = 1'b0;
    @(posedge clk); #1;
    $display("txn %0d: rd=%0b wr=%0b op=%0d addr=%h stall_cycles=%0d mdr=%h mis=%0b err=%0b",
             n_txn, t.rd, t.wr, t.op, t.addr, stalls, mdr_o, t.exp_mis, t.exp_err);
    n_txn++;
  endtask

  txn_t tbl[14];
  txn_t t;

  initial begin
    //        rd    wr    op    addr          wdata          dly rdata          exp_mdr        be     exp_wdata      mis   err
    tbl[0]  = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0,          2,  32'h1234_5678, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd7, 32'h103, 32'h0,          0,  32'h80FF_FFFF, 32'hFFFF_FF80, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd6, 32'h103, 32'h0,          1,  32'h80FF_FFFF, 32'h0000_0080, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 32'h102, 32'h0,          0,  32'h8001_1234, 32'hFFFF_8001, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'd2, 32'h201, 32'hAABB_CCDD,  1,  32'h0,         32'hFFFF_8001, 4'h2, 32'hDDDD_DDDD, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'd1, 32'h202, 32'hAABB_CCDD,  0,  32'h0,         32'hFFFF_8001, 4'hC, 32'hCCDD_CCDD, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'd3, 32'h102, 32'h0,          0,  32'h0,         32'hFFFF_8001, 4'hF, 32'h0,         1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd1, 32'h203, 32'h1111_2222,  0,  32'h0,         32'hFFFF_8001, 4'hC, 32'h2222_2222, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd4, 32'h100, 32'h0,          3,  32'h8001_7FFE, 32'h0000_7FFE, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 32'h010, 32'h0102_0304,  0,  32'h0,         32'h0000_7FFE, 4'hF, 32'h0102_0304, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 32'h020, 32'h0BAD_F00D,  2,  32'h5A5A_5A5A, 32'h0000_7FFE, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'd1, 32'h040, 32'h0,          0,  32'hCAFE_BABE, 32'hCAFE_BABE, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 3'd2, 32'h003, 32'h1234_5678,  0,  32'h0,         32'hCAFE_BABE, 4'h8, 32'h7878_7878, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'd3, 32'h300, 32'h0,         -1,  32'h0,         32'hCAFE_BABE, 4'hF, 32'h0,         1'b0, 1'b1};

    rst_n = 1'b0; rd_i = 1'b0; wr_i = 1'b0; be_op_i = 3'd0; addr_i = 32'd0;
    wdata_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_be", 32'(bus_be_o), 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_mdr", mdr_o, 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) run_txn(tbl[i], 1'b0);

    // Late ack after the timeout abort must be ignored.
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    #1;
    chk("late_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    chk("late_mdr", mdr_o, model_mdr);
    chk("late_ready", 32'(ready_o), 32'd0);
    chk("late_req2", 32'(bus_req_o), 32'd0);
    bus_ack_i = 1'b0;
    @(posedge clk); #1;

    // Request held across DONE starts a second, independent access.
    t = '{1'b1, 1'b0, 3'd3, 32'h500, 32'h0, 0, 32'h1111_2222, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};
    t = model(t, model_mdr);
    run_txn(t, 1'b1);
    t = '{1'b1, 1'b0, 3'd7, 32'h501, 32'h0, 1, 32'h0000_8000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};
    t = model(t, model_mdr);
    chk("held_model", t.exp_mdr, 32'hFFFF_FF80);
    run_txn(t, 1'b0);

    // Asynchronous reset in the middle of REQ.
    rd_i = 1'b1; be_op_i = 3'd3; addr_i = 32'h400;
    @(posedge clk); #1;
    chk("mid_req", 32'(bus_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_mdr", mdr_o, 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    rd_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", 32'(bus_req_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd0);
    chk("post_rst_mdr", mdr_o, 32'd0);
    bus_ack_i = 1'b0;
    model_mdr = 32'd0;
    @(posedge clk); #1;

    // Random accesses checked against the model.
    for (int i = 0; i < 80; i++) begin
      t.wr = 1'($urandom % 2);
      t.rd = t.wr ? 1'($urandom % 2) : 1'b1;
      t.op = t.wr ? 3'($urandom % 3) : 3'($urandom % 8);
      t.addr = $urandom;
      t.wdata = $urandom;
      t.ack_dly = int'($urandom_range(0, 5));
      if (t.ack_dly == 5) t.ack_dly = -1;
      t.rdata = $urandom;
      t = model(t, model_mdr);
      run_txn(t, ($urandom % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard bound on the run in case the DUT wedges the sequencing.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
